// File: rtl/coord_fetcher_pkg.sv
// Shared types and default widths for the coordinate fetcher.
// Optional zero-terminated runs: COORD_FETCHER_ZERO_TERM_EN.
package coord_fetcher_pkg;

  localparam int unsigned CF_ADDR_W = 8;
  localparam int unsigned CF_DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FETCH   = 2'd1,
    ST_PRESENT = 2'd2,
    ST_FINISH  = 2'd3
  } cf_state_e;

endpackage

// File: rtl/coord_fetcher.sv
// Walks an external combinational ROM and streams words over valid/ready.
// Define COORD_FETCHER_ZERO_TERM_EN to end a run on a zero word.
module coord_fetcher
  import coord_fetcher_pkg::*;
#(
  parameter int ADDR_WIDTH = CF_ADDR_W,
  parameter int DATA_WIDTH = CF_DATA_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   max_len,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_data,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH:0]   word_count
);

  cf_state_e             state_q, state_d;
  logic [ADDR_WIDTH-1:0] rom_addr_q, rom_addr_d;
  logic [ADDR_WIDTH:0]   max_len_q, max_len_d;
  logic [ADDR_WIDTH:0]   word_count_q, word_count_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [ADDR_WIDTH:0]   cnt_inc;
  logic                  zero_hit;

`ifdef COORD_FETCHER_ZERO_TERM_EN
  assign zero_hit = (rom_data == '0);
`else
  assign zero_hit = 1'b0;
`endif

  assign cnt_inc = word_count_q + 1'b1;

  // rom_addr only moves when entering FETCH, so it holds elsewhere
  always_comb begin
    state_d      = state_q;
    rom_addr_d   = rom_addr_q;
    max_len_d    = max_len_q;
    word_count_d = word_count_q;
    out_data_d   = out_data_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          max_len_d    = max_len;
          word_count_d = '0;
          if (max_len == '0) begin
            state_d = ST_FINISH;
          end else begin
            state_d    = ST_FETCH;
            rom_addr_d = base_addr;
          end
        end
      end
      ST_FETCH: begin
        if (zero_hit) begin
          state_d = ST_FINISH;
        end else begin
          out_data_d = rom_data;
          state_d    = ST_PRESENT;
        end
      end
      ST_PRESENT: begin
        if (out_ready) begin
          word_count_d = cnt_inc;
          if (cnt_inc == max_len_q) begin
            state_d = ST_FINISH;
          end else begin
            state_d    = ST_FETCH;
            rom_addr_d = rom_addr_q + 1'b1;
          end
        end
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      rom_addr_q   <= '0;
      max_len_q    <= '0;
      word_count_q <= '0;
      out_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      rom_addr_q   <= rom_addr_d;
      max_len_q    <= max_len_d;
      word_count_q <= word_count_d;
      out_data_q   <= out_data_d;
    end
  end

  assign rom_addr   = rom_addr_q;
  assign out_data   = out_data_q;
  assign word_count = word_count_q;
  assign out_valid  = (state_q == ST_PRESENT);
  assign busy       = (state_q == ST_FETCH) ||
                      (state_q == ST_PRESENT);
  assign done       = (state_q == ST_FINISH);

endmodule

// File: tb/tb_coord_fetcher.sv
// Self-checking bench for coord_fetcher against a list-based run model.
// Honours COORD_FETCHER_ZERO_TERM_EN when building expectations.
module tb_coord_fetcher;

  localparam int AW = 8;
  localparam int DW = 32;
`ifdef COORD_FETCHER_ZERO_TERM_EN
  localparam bit ZT = 1'b1;
`else
  localparam bit ZT = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   max_len;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_data;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          busy;
  logic          done;
  logic [AW:0]   word_count;

  logic [DW-1:0] rom [256];
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  assign rom_data = rom[rom_addr];

  coord_fetcher #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .base_addr(base_addr), .max_len(max_len),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .done(done),
    .word_count(word_count)
  );

  // mode 0: ready always, 1: random ready, 2: stall first word 4 cycles
  task automatic run(input int base, input int len, input int mode,
                     input bit noise, input string nm);
    int exp_w[$];
    int exp_a[$];
    int got_w[$];
    int got_a[$];
    int hs_c[$];
    int done_c = -1;
    int stall = 0;
    int nval = 0;
    int r;
    bit stalled = 0;
    bit fin = 0;
    bit tmo = 1;
    logic [DW-1:0] held = '0;
    for (int i = 0; i < len; i++) begin
      int a;
      a = (base + i) % 256;
      exp_a.push_back(a);
      if (ZT && rom[a] == 0) break;
      exp_w.push_back(int'(rom[a]));
    end
    @(negedge clk);
    start = 1'b1;
    base_addr = base[AW-1:0];
    max_len = len[AW:0];
    out_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    r = $urandom;
    base_addr = r[AW-1:0];
    max_len = r[AW+8:8];
    for (int cyc = 0; cyc < 300; cyc++) begin
      if (noise && (busy || done)) begin
        r = $urandom;
        start = r[0];
        base_addr = r[AW:1];
        max_len = r[AW+9:9];
      end else begin
        start = 1'b0;
      end
      if (busy && !out_valid) got_a.push_back(int'(rom_addr));
      if (out_valid) begin
        nval++;
        if (stalled) begin
          n_cmp++;
          if (out_data !== held) begin
            n_bad++;
            $display("FAIL %s hold: out_data=%0d required %0d",
                     nm, out_data, held);
          end
        end
        r = $urandom;
        case (mode)
          0: out_ready = 1'b1;
          1: out_ready = r[0];
          default: out_ready = (stall >= 4);
        endcase
        if (out_ready) begin
          got_w.push_back(int'(out_data));
          hs_c.push_back(cyc);
          stalled = 0;
        end else begin
          stalled = 1;
          held = out_data;
          stall++;
        end
      end else begin
        r = $urandom;
        out_ready = r[0];
      end
      if (fin) begin
        n_cmp++;
        if (done !== 1'b0) begin
          n_bad++;
          $display("FAIL %s done_width: done=%b required 0", nm, done);
        end
        tmo = 0;
        break;
      end
      if (done) begin
        done_c = cyc;
        fin = 1;
        n_cmp++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
          n_bad++;
          $display("FAIL %s finish_flags: busy=%b valid=%b required 0 0",
                   nm, busy, out_valid);
        end
      end
      @(negedge clk);
    end
    start = 1'b0;
    out_ready = 1'b0;
    n_cmp++;
    if (tmo) begin
      n_bad++;
      $display("FAIL %s timeout: done not seen, required within 300", nm);
    end
    n_cmp++;
    if (got_w.size() != exp_w.size()) begin
      n_bad++;
      $display("FAIL %s nwords: got %0d required %0d",
               nm, got_w.size(), exp_w.size());
    end
    for (int i = 0; i < got_w.size() && i < exp_w.size(); i++) begin
      n_cmp++;
      if (got_w[i] != exp_w[i]) begin
        n_bad++;
        $display("FAIL %s word[%0d]: got %0d required %0d",
                 nm, i, got_w[i], exp_w[i]);
      end
    end
    n_cmp++;
    if (got_a.size() != exp_a.size()) begin
      n_bad++;
      $display("FAIL %s naddr: got %0d required %0d",
               nm, got_a.size(), exp_a.size());
    end
    for (int i = 0; i < got_a.size() && i < exp_a.size(); i++) begin
      n_cmp++;
      if (got_a[i] != exp_a[i]) begin
        n_bad++;
        $display("FAIL %s addr[%0d]: got %0d required %0d",
                 nm, i, got_a[i], exp_a[i]);
      end
    end
    n_cmp++;
    if (int'(word_count) != exp_w.size()) begin
      n_bad++;
      $display("FAIL %s word_count: got %0d required %0d",
               nm, word_count, exp_w.size());
    end
    if (exp_w.size() == 0) begin
      n_cmp++;
      if (nval != 0) begin
        n_bad++;
        $display("FAIL %s no_valid: valid cycles %0d required 0", nm, nval);
      end
    end
    if (len == 0) begin
      n_cmp++;
      if (done_c < 0 || done_c > 1) begin
        n_bad++;
        $display("FAIL %s zero_len_done: cycle %0d required 0..1",
                 nm, done_c);
      end
    end
    if (mode == 0) begin
      for (int i = 1; i < hs_c.size(); i++) begin
        n_cmp++;
        if (hs_c[i] - hs_c[i-1] != 2) begin
          n_bad++;
          $display("FAIL %s spacing[%0d]: got %0d required 2",
                   nm, i, hs_c[i] - hs_c[i-1]);
        end
      end
    end
    if (mode == 2 && exp_w.size() > 0) begin
      n_cmp++;
      if (stall != 4) begin
        n_bad++;
        $display("FAIL %s stall_cycles: got %0d required 4", nm, stall);
      end
    end
    repeat (3) @(negedge clk);
    n_cmp++;
    if (int'(word_count) != exp_w.size() || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL %s hold_after: count=%0d busy=%b required %0d 0",
               nm, word_count, busy, exp_w.size());
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    start = 1'b0;
    out_ready = 1'b0;
    base_addr = '0;
    max_len = '0;
    #3;
    n_cmp++;
    if ({out_valid, busy, done} !== 3'b000 || out_data !== '0 ||
        rom_addr !== '0 || word_count !== '0) begin
      n_bad++;
      $display("FAIL reset_state: v%b b%b d%b data=%0d addr=%0d cnt=%0d required all 0",
               out_valid, busy, done, out_data, rom_addr, word_count);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_idle: busy=%b done=%b required 0 0", busy, done);
    end
  endtask

  task automatic test_reset_mid_run;
    int hs = 0;
    bit hit = 0;
    @(negedge clk);
    start = 1'b1;
    base_addr = 8'd0;
    max_len = 9'd6;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (out_valid) begin
        if (hs == 2) begin
          hit = 1;
          break;
        end
        out_ready = 1'b1;
        hs++;
      end
      @(negedge clk);
    end
    out_ready = 1'b0;
    n_cmp++;
    if (!hit) begin
      n_bad++;
      $display("FAIL rst_mid reach: third word not presented, required within 40");
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({out_valid, busy, done} !== 3'b000 || out_data !== '0 ||
        rom_addr !== '0 || word_count !== '0) begin
      n_bad++;
      $display("FAIL rst_mid_state: v%b b%b d%b data=%0d addr=%0d cnt=%0d required all 0",
               out_valid, busy, done, out_data, rom_addr, word_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      n_cmp++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        n_bad++;
        $display("FAIL rst_mid_quiet: done=%b busy=%b required 0 0",
                 done, busy);
      end
    end
    run(0, 6, 0, 0, "post_reset");
  endtask

  task automatic test_directed;
    run(0, 6, 0, 0, "full6");
    run(2, 3, 2, 0, "stall3");
    run(0, 0, 0, 0, "len0");
    run(0, 10, 0, 0, "len10");
    run(254, 4, 0, 0, "wrap");
  endtask

  task automatic test_random;
    for (int k = 0; k < 24; k++) begin
      int b;
      int l;
      b = (k % 2 == 0) ? int'($urandom_range(0, 7)) : int'($urandom_range(0, 255));
      l = int'($urandom_range(0, 12));
      run(b, l, 1, 1, $sformatf("rand%0d", k));
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = '0;
    rom[0] = 32'd1;
    rom[1] = 32'd2;
    rom[2] = 32'd30;
    rom[3] = 32'd40;
    rom[4] = 32'd45;
    rom[5] = 32'd3;
    test_reset();
    test_directed();
    test_reset_mid_run();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
